// File: rtl/cmp_pkg.sv
// Shared definitions for the max-finder controller and the external
// comparator that sits beside it at the top level.
//   maxf_state_t : controller state encoding
//   CMP_W        : comparator operand width (sample width must match)
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } maxf_state_t;

  localparam int CMP_W = 4;

endpackage : cmp_pkg

// File: rtl/max_finder_ctrl_if.sv
// Sample stream into the max-finder controller (valid/ready handshake).
//   in_data  : sample value, producer -> controller
//   in_valid : in_data valid, producer -> controller
//   in_ready : controller accepts a sample this cycle, controller -> producer
// Modports: master = producer side, slave = controller side.
interface max_finder_ctrl_if
  import cmp_pkg::*;
#(
  parameter int DATA_W = CMP_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface : max_finder_ctrl_if

// File: rtl/max_finder_ctrl.sv
// Running-maximum controller. Collects a burst of COUNT unsigned samples,
// one per two clocks, and reports the maximum and the index of its first
// occurrence. The magnitude compare itself is done by an external
// comparator: this block presents the current max on cmp_a and the
// candidate on cmp_b and consumes the combinational cmp_ge flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a burst (only looked at in IDLE)
//   in_if      : sample stream (slave side of max_finder_ctrl_if)
//   cmp_a/b    : comparator operands (registered max / candidate)
//   cmp_ge     : comparator flag, 1 when cmp_a >= cmp_b
//   max_out    : maximum of the last burst
//   max_idx    : 0-based index of the first occurrence of that maximum
//   busy       : high in COLLECT and COMPARE
//   done       : one-cycle pulse when a burst completes
// DATA_W must equal the comparator width CMP_W; COUNT is legal in 1..255.
module max_finder_ctrl
  import cmp_pkg::*;
#(
  parameter  int DATA_W = CMP_W,
  parameter  int COUNT  = 8,
  localparam int CNT_W  = $clog2(COUNT) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  max_finder_ctrl_if.slave  in_if,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_ge,
  output logic [DATA_W-1:0] max_out,
  output logic [CNT_W-1:0]  max_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  maxf_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] cand_q;
  logic              first_q;
  logic              accept;
  logic              take_cand;

  // First sample of a burst always seeds the max; afterwards only a strictly
  // larger candidate replaces it, so ties keep the earliest index.
  assign take_cand = first_q | ~cmp_ge;
  assign accept    = in_if.in_valid & in_if.in_ready;

  // Operands come straight from registers, so they are glitch-free in every
  // state, not just COMPARE.
  assign cmp_a   = max_q;
  assign cmp_b   = cand_q;
  assign max_out = max_q;
  assign max_idx = idx_q;

  always_comb begin
    state_d        = state_q;
    in_if.in_ready = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        in_if.in_ready = 1'b1;
        busy           = 1'b1;
        if (in_if.in_valid) state_d = COMPARE;
      end
      COMPARE: begin
        busy    = 1'b1;
        state_d = (cnt_q == LAST_IDX) ? DONE : COLLECT;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      cand_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          // max_q/idx_q keep the previous result until the new burst's
          // first compare overwrites them.
          if (start) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
            cand_q  <= '0;
          end
        end
        COLLECT: begin
          if (accept) cand_q <= in_if.in_data;
        end
        COMPARE: begin
          if (take_cand) begin
            max_q <= cand_q;
            idx_q <= cnt_q;
          end
          first_q <= 1'b0;
          // Exits to DONE at LAST_IDX, so the counter never wraps.
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule : max_finder_ctrl
